// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, Start/Busy/Done handshake.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds two's-complement operands and a FIX state.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             borrow_s;
    logic [WIDTH-1:0] p_step_s;
    logic [WIDTH-1:0] q_step_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sq_q, sq_d;
    logic sr_q, sr_d;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        neg_f = ~v + WIDTH'(1);
    endfunction

    // Magnitude of a two's-complement value; the most-negative value maps to itself as unsigned.
    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v);
        mag_f = v[WIDTH-1] ? neg_f(v) : v;
    endfunction
`endif

    // One restoring step; P never exceeds WIDTH-1 significant bits before a shift.
    always_comb begin
        shifted_s = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
        diff_s    = {1'b0, shifted_s} - {1'b0, dvs_q};
        borrow_s  = diff_s[WIDTH];
        p_step_s  = borrow_s ? shifted_s : diff_s[WIDTH-1:0];
        q_step_s  = {q_q[WIDTH-2:0], ~borrow_s};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sq_d    = sq_q;
        sr_d    = sr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (Start) begin
                    if (Divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        cnt_d   = '0;
                        p_d     = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        q_d     = mag_f(Dividend);
                        dvs_d   = mag_f(Divisor);
                        sq_d    = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                        sr_d    = Dividend[WIDTH-1];
`else
                        q_d     = Dividend;
                        dvs_d   = Divisor;
`endif
                    end
                end else begin
                    dbz_d = dbz_q;
                end
            end
            S_RUN: begin
                p_d   = p_step_s;
                q_d   = q_step_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    state_d = S_FIX;
`else
                    state_d = S_DONE;
                    quot_d  = q_step_s;
                    rem_d   = p_step_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = S_RUN;
                end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            S_FIX: begin
                state_d = S_DONE;
                quot_d  = sq_q ? neg_f(q_q) : q_q;
                rem_d   = sr_q ? neg_f(p_q) : p_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sq_q    <= sq_d;
            sr_q    <= sr_d;
`endif
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed test-plan cases plus randomized operands
// checked against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int checks;
    int failures;

    seq_divider #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
        .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: plain division; edges = clock edges after the Start edge until Done is seen.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int edges);
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1; edges = 0;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            int sa, sb;
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0; edges = W + 1;
`else
            q = a / b; r = a % b; dz = 1'b0; edges = W;
`endif
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one Start; after the accept edge drive Start=hold with operands na/nb, then wait for Done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hold, input logic [W-1:0] na, input logic [W-1:0] nb,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int edges, output int busy_cnt, output logic timeout);
        Start = 1'b1; Dividend = a; Divisor = b;
        tick();
        Start = hold; Dividend = na; Divisor = nb;
        edges = 0; busy_cnt = 0;
        while (!Done && edges < 60) begin
            if (Busy) busy_cnt++;
            tick();
            edges++;
        end
        timeout = !Done;
        q = Quotient; r = Remainder; dz = DivByZero;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, to;
        int e, bc, ee;
        model(a, b, eq, er, edz, ee);
        run_op(a, b, 1'b0, W'($urandom), W'($urandom), q, r, dz, e, bc, to);
        checks++;
        if (to || q !== eq || r !== er || dz !== edz || e !== ee) begin
            failures++;
            $display("FAIL %s %0d/%0d: got q=%0d r=%0d dz=%0b edges=%0d to=%0b, want q=%0d r=%0d dz=%0b edges=%0d",
                     name, a, b, q, r, dz, e, to, eq, er, edz, ee);
        end
        tick();
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Start = 1'b1; Dividend = 8'd100; Divisor = 8'd7;
        tick(); tick();
        Start = 1'b0; Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({Quotient, Remainder, Busy, Done, DivByZero} !== {(2 * W + 3){1'b0}}) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got q=%0h r=%0h busy=%0b done=%0b dz=%0b, want all 0",
                         i, Quotient, Remainder, Busy, Done, DivByZero);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, to;
        int e, bc, ee;
        model(8'd100, 8'd7, eq, er, edz, ee);
        run_op(8'd100, 8'd7, 1'b0, 8'd3, 8'd0, q, r, dz, e, bc, to);
        checks++;
        if (to || q !== 8'd14 || r !== 8'd2 || dz !== 1'b0 || q !== eq || r !== er) begin
            failures++;
            $display("FAIL basic_100_7: got q=%0d r=%0d dz=%0b to=%0b, want q=14 r=2 dz=0", q, r, dz, to);
        end
        checks++;
        if (bc !== ee || e !== ee) begin
            failures++;
            $display("FAIL basic_latency: got busy=%0d edges=%0d, want %0d", bc, e, ee);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== eq || Remainder !== er) begin
            failures++;
            $display("FAIL done_pulse_hold: got done=%0b busy=%0b q=%0d r=%0d, want 0 0 %0d %0d",
                     Done, Busy, Quotient, Remainder, eq, er);
        end
        tick();
    endtask

    task automatic test_div_zero();
        check_op("div0_5_0", 8'd5, 8'd0);
        check_op("after_div0_9_3", 8'd9, 8'd3);
    endtask

    task automatic test_edges();
        check_op("edge_255_1", 8'd255, 8'd1);
        check_op("edge_3_10", 8'd3, 8'd10);
        check_op("edge_255_255", 8'd255, 8'd255);
        check_op("edge_0_7", 8'd0, 8'd7);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, to;
        int e, bc, ee;
        model(8'd200, 8'd9, eq, er, edz, ee);
        run_op(8'd200, 8'd9, 1'b1, 8'd50, 8'd5, q, r, dz, e, bc, to);
        checks++;
        if (to || q !== eq || r !== er || e !== ee) begin
            failures++;
            $display("FAIL b2b_first: got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=%0d", q, r, e, eq, er, ee);
        end
        model(8'd50, 8'd5, eq, er, edz, ee);
        run_op(8'd50, 8'd5, 1'b0, 8'd1, 8'd1, q, r, dz, e, bc, to);
        checks++;
        if (to || q !== eq || r !== er || e !== ee) begin
            failures++;
            $display("FAIL b2b_second: got q=%0d r=%0d edges=%0d, want q=%0d r=%0d edges=%0d", q, r, e, eq, er, ee);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int dones;
        Start = 1'b1; Dividend = 8'd77; Divisor = 8'd4;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1;
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== {(2 * W + 3){1'b0}}) begin
            failures++;
            $display("FAIL abort_clear: got q=%0h r=%0h busy=%0b done=%0b dz=%0b, want all 0",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (Done || Busy) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", dones);
        end
        check_op("after_abort_77_4", 8'd77, 8'd4);
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        check_op("signed_m7_2", 8'hF9, 8'd2);
        check_op("signed_7_m2", 8'd7, 8'hFE);
        check_op("signed_m128_m1", 8'h80, 8'hFF);
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            check_op("random", a, b);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        Rst_n = 1'b0; Start = 1'b0; Dividend = '0; Divisor = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_edges();
        test_back_to_back();
        test_reset_abort();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
